vga_sprite_display: RTL and testbench

VGA_SPRITE_DISPLAY -- requirements
Module: vga_sprite_display

---
 rtl/vga_sprite_display_if.sv | 12 +
 rtl/vga_sprite_display.sv | 142 ++++++++++++++
 tb/tb_vga_sprite_display.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sprite_display_if.sv
// CPU register bus into the sprite display: chip select, write strobe, word address, data.
// Writes land on the clk edge they are presented; reads return one clk later; never stalls.
interface vga_sprite_display_if;
  logic        enable;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output enable, MemWrite, DataAdr, WriteData, input ReadData);
  modport slave  (input enable, MemWrite, DataAdr, WriteData, output ReadData);
endinterface

// File: rtl/vga_sprite_display.sv
// 640x480 VGA timing with three double-buffered 16x16 sprites; pixels emerge one tick after the counters.
// CPU bus is never stalled: writes hit staging at once, readback is registered one clk later.
module vga_sprite_display #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_sprite_display_if.slave  bus,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_N,
  output logic                 VGA_SYNC_N,
  output logic                 VGA_Clock
);
  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VEND   = 10'(H_VIS);
  localparam logic [9:0] V_VEND   = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic        phase;
  logic [9:0]  hcount, vcount;
  logic [9:0]  stg [6];
  logic [9:0]  act [6];
  logic [2:0]  stg_ctrl, act_ctrl;
  logic [7:0]  frame_count;
  logic [2:0]  sel;
  logic        wr_en, rd_en, commit, visible, vblank;
  logic [31:0] rd_val;
  logic [23:0] rgb;
  logic        unused_bus_bits;

  assign sel        = bus.DataAdr[4:2];
  assign wr_en      = bus.enable && bus.MemWrite;
  assign rd_en      = bus.enable && !bus.MemWrite;
  assign commit     = phase && (hcount == 10'd0) && (vcount == V_VEND);
  assign visible    = (hcount < H_VEND) && (vcount < V_VEND);
  assign vblank     = vcount >= V_VEND;
  assign VGA_SYNC_N = 1'b0;
  assign VGA_Clock  = phase;
  assign unused_bus_bits = ^{bus.DataAdr[31:5], bus.DataAdr[1:0], bus.WriteData[31:10]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  // Commit copies the pre-edge staging values, so a write in the same clk waits for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        stg[i] <= '0;
        act[i] <= '0;
      end
      stg_ctrl    <= '0;
      act_ctrl    <= '0;
      frame_count <= '0;
    end else begin
      if (wr_en) begin
        if (sel <= 3'd5) stg[sel] <= bus.WriteData[9:0];
        else if (sel == 3'd6) stg_ctrl <= bus.WriteData[2:0];
      end
      if (commit) begin
        for (int i = 0; i < 6; i++) act[i] <= stg[i];
        act_ctrl    <= stg_ctrl;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      3'd6:    rd_val = {29'd0, stg_ctrl};
      3'd7:    rd_val = {22'd0, vblank, frame_count, 1'b0};
      default: rd_val = {22'd0, stg[sel]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      bus.ReadData <= '0;
    else if (rd_en) bus.ReadData <= rd_val;
  end

  // 11-bit compare keeps X+15 from wrapping, so sprites clip at the right/bottom edge.
  function automatic logic hit(input logic [9:0] x, input logic [9:0] y,
                               input logic [9:0] h, input logic [9:0] v);
    logic [10:0] x_end, y_end;
    x_end = {1'b0, x} + 11'd15;
    y_end = {1'b0, y} + 11'd15;
    return ({1'b0, h} >= {1'b0, x}) && ({1'b0, h} <= x_end) &&
           ({1'b0, v} >= {1'b0, y}) && ({1'b0, v} <= y_end);
  endfunction

  always_comb begin
    rgb = 24'h000000;
    if (act_ctrl[0] && hit(act[0], act[1], hcount, vcount)) rgb = 24'h00FF00;
    if (act_ctrl[1] && hit(act[2], act[3], hcount, vcount)) rgb = 24'hFF0000;
    if (act_ctrl[2] && hit(act[4], act[5], hcount, vcount)) rgb = 24'h0000FF;
    if (!visible) rgb = 24'h000000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      VGA_BLANK_N           <= 1'b0;
      VGA_HS                <= 1'b1;
      VGA_VS                <= 1'b1;
    end else if (phase) begin
      {VGA_R, VGA_G, VGA_B} <= rgb;
      VGA_BLANK_N           <= visible;
      VGA_HS                <= !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
      VGA_VS                <= !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
    end
  end
endmodule

// File: tb/tb_vga_sprite_display.sv
// Directed bench for vga_sprite_display on a reduced raster (40x24 total, 32x20 visible).
// Pixel and readback expectations are queued as stimulus is driven and popped as the DUT emits them.
module tb_vga_sprite_display;
  localparam int HV = 32, HF = 2, HSY = 4, HB = 2;
  localparam int VV = 20, VF = 1, VSY = 2, VB = 1;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FRAME_CLK = 2 * HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clock;

  vga_sprite_display_if bus ();

  vga_sprite_display #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n),
    .VGA_SYNC_N(vga_sync_n), .VGA_Clock(vga_clock)
  );

  always #10 clk = ~clk;

  // Reference raster position; emit_* is the position whose pixel the last tick edge produced.
  int mh, mv, mph, emit_h, emit_v, emit_tick, mcommits;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mh <= 0; mv <= 0; mph <= 0; emit_h <= 0; emit_v <= 0; emit_tick <= 0; mcommits <= 0;
    end else begin
      emit_tick <= mph; emit_h <= mh; emit_v <= mv;
      mph <= 1 - mph;
      if (mph == 1) begin
        if (mh == HT - 1) begin
          mh <= 0;
          mv <= (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh <= mh + 1;
        end
        if (mh == 0 && mv == VV) mcommits <= mcommits + 1;
      end
    end
  end

  typedef struct { int h; int v; logic [23:0] rgb; } px_t;
  px_t         pq[$];
  logic [31:0] rq[$];
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_px(input int h, input int v, input logic [23:0] rgb);
    px_t e;
    e.h = h; e.v = v; e.rgb = rgb;
    pq.push_back(e);
  endtask

  task automatic drain(input int budget);
    int   n;
    px_t  e;
    logic vis;
    n = 0;
    while (pq.size() > 0 && n < budget) begin
      @(posedge clk); #1; n++;
      if (emit_tick == 1 && emit_h == pq[0].h && emit_v == pq[0].v) begin
        e   = pq.pop_front();
        vis = (e.h < HV) && (e.v < VV);
        check($sformatf("pixel(%0d,%0d)", e.h, e.v),
              {7'd0, vga_blank_n, vga_r, vga_g, vga_b}, {7'd0, vis, e.rgb});
      end
    end
    if (pq.size() > 0) begin
      check("pixel_timeout", pq.size(), 0);
      pq.delete();
    end
  endtask

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(mh == h && mv == v && mph == 1) && n < FRAME_CLK + 4) begin
      @(posedge clk); #1; n++;
    end
    if (n >= FRAME_CLK + 4) check("wait_pos_timeout", n, 0);
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    bus.enable = 1'b1; bus.MemWrite = 1'b1;
    bus.DataAdr = 32'(idx * 4); bus.WriteData = d;
    @(posedge clk); #1;
    bus.enable = 1'b0; bus.MemWrite = 1'b0;
  endtask

  task automatic rd(input int idx, input logic [31:0] exp, input string tag);
    bus.enable = 1'b1; bus.MemWrite = 1'b0;
    bus.DataAdr = 32'h1000_0003 | (32'(idx) << 2);
    rq.push_back(exp);
    @(posedge clk); #1;
    bus.enable = 1'b0;
    check(tag, bus.ReadData, rq.pop_front());
  endtask

  initial begin
    int n, t;
    bus.enable = 1'b0; bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
    #1 reset = 1'b1;
    #4;
    check("rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    check("rst_blank_n", {31'd0, vga_blank_n}, 32'd0);
    check("rst_hs_vs", {30'd0, vga_hs, vga_vs}, 32'd3);
    check("rst_readdata", bus.ReadData, 32'd0);
    check("sync_n_and_clock", {30'd0, vga_sync_n, vga_clock}, 32'd0);
    #20 reset = 1'b0;

    // Raster timing
    n = 0;
    while (vga_vs !== 1'b0 && n < 2 * FRAME_CLK) begin @(posedge clk); #1; n++; end
    check("vs_first_fall_clk", n, 2 * (VV + VF) * HT + 2);
    check("vs_fall_line", emit_v, VV + VF);
    t = 0;
    while (vga_vs === 1'b0 && t < FRAME_CLK) begin @(posedge clk); #1; t++; end
    check("vs_low_clk", t, 2 * VSY * HT);
    n = 0;
    while (vga_vs !== 1'b0 && n < 2 * FRAME_CLK) begin @(posedge clk); #1; n++; end
    check("frame_period_clk", t + n, FRAME_CLK);
    n = 0;
    while (vga_hs !== 1'b0 && n < 4 * HT) begin @(posedge clk); #1; n++; end
    check("hs_fall_hcount", emit_h, HV + HF);
    t = 0;
    while (vga_hs === 1'b0 && t < 4 * HT) begin @(posedge clk); #1; t++; end
    check("hs_low_clk", t, 2 * HSY);

    // Register readback
    wr(3, 32'hFFFF_F1FF);
    rd(3, 32'h0000_01FF, "rd_bomb_y");
    wr(0, 32'h0000_07FF);
    rd(0, 32'h0000_03FF, "rd_life_x");
    wr(6, 32'hFFFF_FFF5);
    rd(6, 32'h0000_0005, "rd_ctrl");
    wr(7, 32'hFFFF_FFFF);
    rd(6, 32'h0000_0005, "rd_ctrl_after_status_wr");
    wr(1, 32'h0000_0155);
    check("rd_hold", bus.ReadData, 32'h0000_0005);
    rd(1, 32'h0000_0155, "rd_life_y");

    // Commit: staging writes do not touch the current frame
    wait_pos(0, 2);
    wr(0, 4); wr(1, 8); wr(6, 1);
    push_px(4, 8, 24'h000000);
    push_px(4, 8, 24'h00FF00);
    push_px(19, 8, 24'h00FF00);
    push_px(20, 8, 24'h000000);
    push_px(HV + 1, 8, 24'h000000);
    drain(3 * FRAME_CLK);

    // Priority: enemy > bomb > life
    wr(0, 4); wr(1, 4); wr(2, 0); wr(3, 0); wr(4, 8); wr(5, 8); wr(6, 7);
    wait_pos(1, VV);
    push_px(2, 2, 24'hFF0000);
    push_px(5, 5, 24'hFF0000);
    push_px(18, 5, 24'h00FF00);
    push_px(10, 10, 24'h0000FF);
    push_px(24, 10, 24'h000000);
    drain(2 * FRAME_CLK);

    // Right-edge clip, no wrap into the next line
    wr(4, HV - 2); wr(5, 12); wr(6, 4);
    wait_pos(1, VV);
    push_px(29, 12, 24'h000000);
    push_px(31, 12, 24'h0000FF);
    push_px(HV + 1, 12, 24'h000000);
    push_px(0, 13, 24'h000000);
    drain(2 * FRAME_CLK);

    // Write landing on the commit clk
    wr(0, 4); wr(1, 8); wr(6, 1);
    wait_pos(1, VV);
    wait_pos(0, VV);
    wr(0, 10);
    push_px(5, 8, 24'h00FF00);
    push_px(22, 8, 24'h000000);
    push_px(5, 8, 24'h000000);
    push_px(22, 8, 24'h00FF00);
    drain(3 * FRAME_CLK);

    // frame_count wrap in STATUS
    n = 0;
    while (mcommits < 255 && n < 300 * FRAME_CLK) begin @(posedge clk); #1; n++; end
    rd(7, 32'h0000_03FE, "status_fc255");
    n = 0;
    while (mcommits < 256 && n < 2 * FRAME_CLK) begin @(posedge clk); #1; n++; end
    rd(7, 32'h0000_0200, "status_fc0");

    // Asynchronous reset mid-frame
    wait_pos(12, 10);
    @(posedge clk); #1;
    check("pre_rst_pixel", {8'd0, vga_r, vga_g, vga_b}, 32'h0000_FF00);
    #2 reset = 1'b1;
    #1;
    check("midrst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    check("midrst_blank_n", {31'd0, vga_blank_n}, 32'd0);
    check("midrst_hs_vs", {30'd0, vga_hs, vga_vs}, 32'd3);
    check("midrst_readdata", bus.ReadData, 32'd0);
    #4 reset = 1'b0;
    n = 0;
    while (vga_vs !== 1'b0 && n < 2 * FRAME_CLK) begin @(posedge clk); #1; n++; end
    check("vs_fall_after_reset_clk", n, 2 * (VV + VF) * HT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
